// File: rtl/gt_streak_monitor.sv
// gt_streak_monitor
//   Consumes results of the 2-bit greater-than comparator under a valid/ready
//   handshake. Over a window of WINDOW accepted samples it counts A>B results
//   and tracks the current and longest run of consecutive A>B. It then emits
//   one summary on an out_valid/out_ready handshake.
//
//   Optional feature: define GT_CHECK_EN to add the gt_err port. The monitor
//   then recomputes in_a > in_b on each accept and sets a sticky mismatch flag.
//   Without the macro, in_a/in_b are unused and gt_err does not exist.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   in_valid       in   comparator sample present
//   in_ready       out  monitor can accept a sample (0 in REPORT and during rst)
//   in_a, in_b     in   operands as applied to the comparator (W bits)
//   in_gt          in   comparator output F (1 = A>B)
//   out_valid      out  window summary available
//   out_ready      in   downstream takes the summary
//   out_gt_count   out  number of in_gt=1 samples in the window (CW bits)
//   out_max_streak out  longest run of consecutive in_gt=1 (CW bits)
//   streak_hit     out  one-cycle pulse after the accept that makes the run == THRESH
//   gt_err         out  sticky comparator-mismatch flag (GT_CHECK_EN only)
module gt_streak_monitor #(
  parameter int unsigned W      = 2,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CW     = 5,
  parameter int unsigned THRESH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_gt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_gt_count,
  output logic [CW-1:0] out_max_streak,
  output logic          streak_hit
`ifdef GT_CHECK_EN
  ,
  output logic          gt_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
  localparam logic [CW-1:0] THR_C = CW'(THRESH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_sample_cnt;
  logic [CW-1:0] r_gt_cnt;
  logic [CW-1:0] r_streak;
  logic [CW-1:0] r_max_streak;

  logic          r_out_valid;
  logic [CW-1:0] r_out_gt;
  logic [CW-1:0] r_out_max;
  logic          r_hit;

  logic          w_accept;
  logic          w_last;
  logic          w_report_done;
  logic [CW-1:0] w_sample_inc;
  logic [CW-1:0] w_streak_inc;
  logic [CW-1:0] w_gt_nxt;
  logic [CW-1:0] w_streak_nxt;
  logic [CW-1:0] w_max_nxt;

  assign w_sample_inc = r_sample_cnt + ONE_C;
  assign w_streak_inc = r_streak + ONE_C;
  assign w_last       = (w_sample_inc == WIN_C);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake decode
  always_comb begin
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    w_accept      = 1'b0;
    w_report_done = 1'b0;
    unique case (r_state)
      S_IDLE, S_ACCUM: begin
        in_ready = !rst;
        w_accept = in_valid && !rst;
        if (w_accept) begin
          w_state_nxt = w_last ? S_REPORT : S_ACCUM;
        end
      end
      S_REPORT: begin
        w_report_done = r_out_valid && out_ready;
        if (w_report_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-accept counter updates
  always_comb begin
    w_gt_nxt     = r_gt_cnt;
    w_streak_nxt = '0;
    w_max_nxt    = r_max_streak;
    if (in_gt) begin
      w_gt_nxt     = r_gt_cnt + ONE_C;
      w_streak_nxt = w_streak_inc;
      if (w_streak_inc > r_max_streak) begin
        w_max_nxt = w_streak_inc;
      end
    end
  end

  // Window counters, summary registers and streak pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_cnt <= '0;
      r_gt_cnt     <= '0;
      r_streak     <= '0;
      r_max_streak <= '0;
      r_out_valid  <= 1'b0;
      r_out_gt     <= '0;
      r_out_max    <= '0;
      r_hit        <= 1'b0;
    end else begin
      // The run only grows past THRESH until broken, so equality fires once per run
      r_hit <= w_accept && in_gt && (w_streak_inc == THR_C);
      if (w_accept) begin
        r_sample_cnt <= w_sample_inc;
        r_gt_cnt     <= w_gt_nxt;
        r_streak     <= w_streak_nxt;
        r_max_streak <= w_max_nxt;
        if (w_last) begin
          r_out_gt    <= w_gt_nxt;
          r_out_max   <= w_max_nxt;
          r_out_valid <= 1'b1;
        end
      end else if (w_report_done) begin
        r_sample_cnt <= '0;
        r_gt_cnt     <= '0;
        r_streak     <= '0;
        r_max_streak <= '0;
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_gt_count   = r_out_gt;
  assign out_max_streak = r_out_max;
  assign streak_hit     = r_hit;

`ifdef GT_CHECK_EN
  logic r_gt_err;
  logic w_gt_calc;

  assign w_gt_calc = (in_a > in_b);

  // Sticky until reset; in_gt remains authoritative for counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gt_err <= 1'b0;
    end else if (w_accept && (w_gt_calc != in_gt)) begin
      r_gt_err <= 1'b1;
    end
  end

  assign gt_err = r_gt_err;
`else
  logic w_unused_operands;
  assign w_unused_operands = ^{in_a, in_b};
`endif

endmodule

// File: tb/tb_gt_streak_monitor.sv
// Testbench for gt_streak_monitor. Random windows are checked against a
// reference that keeps the accepted in_gt history of the current window in a
// queue and derives counts and runs from it.
module tb_gt_streak_monitor;

  localparam int WINDOW = 16;
  localparam int THRESH = 3;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_a;
  logic [1:0]    in_b;
  logic          in_gt;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_gt_count;
  logic [CW-1:0] out_max_streak;
  logic          streak_hit;
`ifdef GT_CHECK_EN
  logic          gt_err;
`endif

  int checks = 0;
  int errors = 0;
  int win_q[$];

  always #5 clk = ~clk;

  gt_streak_monitor #(
    .W(2),
    .WINDOW(WINDOW),
    .CW(CW),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_gt(in_gt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gt_count(out_gt_count),
    .out_max_streak(out_max_streak),
    .streak_hit(streak_hit)
`ifdef GT_CHECK_EN
    ,
    .gt_err(gt_err)
`endif
  );

  // Reference model over the accepted history of the current window
  function automatic int m_count();
    int c = 0;
    foreach (win_q[i]) c += win_q[i];
    return c;
  endfunction

  function automatic int m_maxrun();
    int best = 0;
    int run = 0;
    foreach (win_q[i]) begin
      run = (win_q[i] != 0) ? run + 1 : 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  function automatic int m_currun();
    int r = 0;
    for (int i = win_q.size() - 1; i >= 0; i--) begin
      if (win_q[i] == 0) break;
      r++;
    end
    return r;
  endfunction

  // Drives one sample for one clock; returns in_ready seen before the edge and
  // streak_hit/out_valid seen after it. Operands agree with gt unless bad=1.
  task automatic do_accept(input bit gt, input bit bad,
                           output bit hit, output bit ov, output bit rdy);
    logic [1:0] a;
    logic [1:0] b;
    if (bad) begin
      a = 2'd2;
      b = 2'd1;
    end else if (gt) begin
      b = 2'($urandom_range(2, 0));
      a = 2'($urandom_range(3, 32'(b) + 1));
    end else begin
      a = 2'($urandom_range(3, 0));
      b = 2'($urandom_range(3, 32'(a)));
    end
    in_a = a;
    in_b = b;
    in_gt = gt;
    in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_gt = 1'($urandom);
    in_a = 2'($urandom);
    in_b = 2'($urandom);
    hit = streak_hit;
    ov = out_valid;
    win_q.push_back(gt ? 1 : 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_gt = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    checks++;
    if (out_gt_count !== '0 || out_max_streak !== '0) begin
      errors++;
      $display("FAIL reset counts: got %0d/%0d exp 0/0", out_gt_count, out_max_streak);
    end
    checks++;
    if (streak_hit !== 1'b0) begin errors++; $display("FAIL reset streak_hit: got %b exp 0", streak_hit); end
`ifdef GT_CHECK_EN
    checks++;
    if (gt_err !== 1'b0) begin errors++; $display("FAIL reset gt_err: got %b exp 0", gt_err); end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset idle in_ready: got %b exp 1", in_ready); end
    win_q.delete();
  endtask

  // One full window: gts[i] is the i-th accepted in_gt, gaps[i] inserts three
  // idle cycles after sample i, hold is the number of cycles out_ready stays 0.
  task automatic test_window(input string tag, input logic [WINDOW-1:0] gts,
                             input logic [WINDOW-1:0] gaps, input int hold);
    bit hit, ov, rdy, e_hit, e_ov;
    logic [CW-1:0] e_cnt, e_max;
    for (int i = 0; i < WINDOW; i++) begin
      do_accept(gts[i], 1'b0, hit, ov, rdy);
      e_hit = gts[i] && (m_currun() == THRESH);
      e_ov = (i == WINDOW - 1);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL %s in_ready[%0d]: got %b exp 1", tag, i, rdy); end
      checks++;
      if (hit !== e_hit) begin errors++; $display("FAIL %s streak_hit[%0d]: got %b exp %b", tag, i, hit, e_hit); end
      checks++;
      if (ov !== e_ov) begin errors++; $display("FAIL %s out_valid[%0d]: got %b exp %b", tag, i, ov, e_ov); end
      if (gaps[i] && i < WINDOW - 1) begin
        for (int g = 0; g < 3; g++) begin
          @(posedge clk);
          #1;
          checks++;
          if (streak_hit !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s gap[%0d]: hit/ov got %b/%b exp 0/0", tag, i, streak_hit, out_valid);
          end
        end
      end
    end
    e_cnt = CW'(m_count());
    e_max = CW'(m_maxrun());
    checks++;
    if (out_gt_count !== e_cnt) begin errors++; $display("FAIL %s out_gt_count: got %0d exp %0d", tag, out_gt_count, e_cnt); end
    checks++;
    if (out_max_streak !== e_max) begin errors++; $display("FAIL %s out_max_streak: got %0d exp %0d", tag, out_max_streak, e_max); end
    // Backpressure: offered samples must be ignored, summary must hold
    for (int c = 0; c < hold; c++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_gt = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || streak_hit !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d] ov/rdy/hit: got %b/%b/%b exp 1/0/0", tag, c, out_valid, in_ready, streak_hit);
      end
      checks++;
      if (out_gt_count !== e_cnt || out_max_streak !== e_max) begin
        errors++;
        $display("FAIL %s hold[%0d] counts: got %0d/%0d exp %0d/%0d", tag, c, out_gt_count, out_max_streak, e_cnt, e_max);
      end
    end
    // Handshake with in_valid still high: nothing may be accepted on this edge
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_gt = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release ov/rdy: got %b/%b exp 0/1", tag, out_valid, in_ready);
    end
    checks++;
    if (out_gt_count !== e_cnt || out_max_streak !== e_max) begin
      errors++;
      $display("FAIL %s kept counts: got %0d/%0d exp %0d/%0d", tag, out_gt_count, out_max_streak, e_cnt, e_max);
    end
    win_q.delete();
  endtask

  task automatic test_mid_reset();
    bit hit, ov, rdy;
    for (int i = 0; i < 7; i++) begin
      do_accept(1'($urandom), 1'b0, hit, ov, rdy);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL mid_reset ov[%0d]: got %b exp 0", i, ov); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset in_ready: got %b exp 0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    win_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || streak_hit !== 1'b0 || out_gt_count !== '0 || out_max_streak !== '0) begin
        errors++;
        $display("FAIL mid_reset idle[%0d]: ov/hit/cnt/max got %b/%b/%0d/%0d exp 0/0/0/0",
                 c, out_valid, streak_hit, out_gt_count, out_max_streak);
      end
    end
    test_window("after_reset", WINDOW'($urandom | $urandom), '0, 2);
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 6; w++) begin
      test_window("random", WINDOW'($urandom | $urandom),
                  WINDOW'($urandom & $urandom & $urandom), int'($urandom_range(4, 0)));
    end
  endtask

`ifdef GT_CHECK_EN
  task automatic test_gt_check();
    bit hit, ov, rdy;
    checks++;
    if (gt_err !== 1'b0) begin errors++; $display("FAIL gt_check pre gt_err: got %b exp 0", gt_err); end
    do_accept(1'b0, 1'b1, hit, ov, rdy);
    checks++;
    if (gt_err !== 1'b1) begin errors++; $display("FAIL gt_check set gt_err: got %b exp 1", gt_err); end
    for (int i = 1; i < WINDOW; i++) begin
      do_accept(1'($urandom), 1'b0, hit, ov, rdy);
      checks++;
      if (gt_err !== 1'b1) begin errors++; $display("FAIL gt_check sticky[%0d]: got %b exp 1", i, gt_err); end
    end
    checks++;
    if (out_valid !== 1'b1 || out_gt_count !== CW'(m_count())) begin
      errors++;
      $display("FAIL gt_check report ov/cnt: got %b/%0d exp 1/%0d", out_valid, out_gt_count, m_count());
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    win_q.delete();
    checks++;
    if (gt_err !== 1'b1) begin errors++; $display("FAIL gt_check after report: got %b exp 1", gt_err); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (gt_err !== 1'b0) begin errors++; $display("FAIL gt_check rst clear: got %b exp 0", gt_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_window("all_ones", '1, '0, 0);
    test_window("alternating", 16'h5555, '0, 0);
    test_window("backpressure", WINDOW'($urandom), '0, 5);
    test_mid_reset();
    test_window("gaps", 16'h0007, 16'h0002, 1);
    test_back_to_back();
`ifdef GT_CHECK_EN
    test_gt_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
